// File: rtl/addsub_nibble_seq.sv
// Wide add/subtract sequencer: streams WIDTH-bit operands through one shared
// 4-bit adder/subtractor slice, LSB nibble first, carry chained in a register.
module addsub_nibble_seq #(
    parameter int  NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic [3:0]       au_in1,
    output logic [3:0]       au_in2,
    output logic             au_carry_in,
    output logic             au_control,
    input  logic [3:0]       au_out,
    input  logic             au_carry_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [3:0]       r_idx;
    logic             r_creg;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;
    logic             w_ovf;

    assign w_accept = (r_state == S_IDLE) && start_valid;
    assign w_last   = (r_idx == LAST_IDX);
    // Signed overflow: operands (after subtract inversion) agree in sign but the sum's sign differs.
    assign w_ovf    = (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) && (au_out[3] != r_a[WIDTH-1]);

    assign result    = r_result;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        au_in1      = 4'd0;
        au_in2      = 4'd0;
        au_carry_in = 1'b0;
        au_control  = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                au_in1      = r_a[4*r_idx +: 4];
                au_in2      = r_b[4*r_idx +: 4];
                au_carry_in = r_creg;
                au_control  = r_sub;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_idx    <= 4'd0;
            r_creg   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Carry-in of the first pass is the +1 of two's-complement subtraction.
            r_a    <= op_a;
            r_b    <= op_b;
            r_sub  <= op_sub;
            r_idx  <= 4'd0;
            r_creg <= op_sub;
        end else if (r_state == S_RUN) begin
            r_result[4*r_idx +: 4] <= au_out;
            r_creg                 <= au_carry_out;
            r_idx                  <= r_idx + 4'd1;
            if (w_last) begin
                r_carry <= au_carry_out;
                r_ovf   <= w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Scoreboard bench for addsub_nibble_seq: driver pushes reference results, a
// negedge monitor pops and compares on every completed result handshake.
module tb_addsub_nibble_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [3:0]   au_in1;
    logic [3:0]   au_in2;
    logic         au_carry_in;
    logic         au_control;
    logic [3:0]   au_out;
    logic         au_carry_out;
    logic [4:0]   slice_sum;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    addsub_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .done_valid(done_valid), .done_ready(done_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .au_in1(au_in1), .au_in2(au_in2), .au_carry_in(au_carry_in), .au_control(au_control),
        .au_out(au_out), .au_carry_out(au_carry_out)
    );

    // Behavioural 4-bit adder/subtractor slice.
    always_comb slice_sum = {1'b0, au_in1} + {1'b0, (au_control ? ~au_in2 : au_in2)} + {4'd0, au_carry_in};
    assign au_out       = slice_sum[3:0];
    assign au_carry_out = slice_sum[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        e.res = ur[W-1:0];
        e.c   = sub ? (ua >= ub) : (ur >= (1 << W));
        e.v   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done_valid && done_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result 0x%0h with no operation pending", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("carry_out", 32'(carry_out), 32'(e.c));
                check("overflow", 32'(overflow), 32'(e.v));
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Called at #1 after a posedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input exp_t e);
        int n;
        op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
        check("start_ready_idle", 32'(start_ready), 32'd1);
        @(posedge clk);
        q.push_back(e);
        #1;
        start_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
        check("start_ready_run", 32'(start_ready), 32'd0);
        wait_done(n);
        check("latency", 32'(n), 32'(NIB));
        @(posedge clk); #1;
        check("result_held_idle", 32'(result), 32'(e.res));
        check("au_zero_idle", 32'({au_in1, au_in2, au_carry_in, au_control}), 32'd0);
    endtask

    initial begin
        int      n;
        int      seen;
        logic [W-1:0] held;
        logic [W-1:0] ra, rb;
        logic    rs;
        exp_t    e1, e2;

        reset = 1'b1; start_valid = 1'b0; done_ready = 1'b1;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry_out, overflow}), 32'd0);
        reset = 1'b0;

        do_op(16'h1234, 16'h0FCD, 1'b0, '{res: 16'h2201, c: 1'b0, v: 1'b0});
        do_op(16'h0005, 16'h0007, 1'b1, '{res: 16'hFFFE, c: 1'b0, v: 1'b0});
        do_op(16'h8000, 16'h0001, 1'b1, '{res: 16'h7FFF, c: 1'b1, v: 1'b1});
        do_op(16'h7FFF, 16'h0001, 1'b0, '{res: 16'h8000, c: 1'b0, v: 1'b1});
        do_op(16'hFFFF, 16'h0001, 1'b0, '{res: 16'h0000, c: 1'b1, v: 1'b0});

        // Backpressure: result held while a second request waits.
        e1 = ref_model(16'h1234, 16'h0FCD, 1'b0);
        e2 = ref_model(16'hFFFF, 16'h0001, 1'b0);
        op_a = 16'h1234; op_b = 16'h0FCD; op_sub = 1'b0;
        start_valid = 1'b1; done_ready = 1'b0;
        @(posedge clk);
        q.push_back(e1);
        #1;
        op_a = 16'hFFFF; op_b = 16'h0001; op_sub = 1'b0;
        wait_done(n);
        check("bp_latency", 32'(n), 32'(NIB));
        held = result;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_done_valid", 32'(done_valid), 32'd1);
            check("bp_result_stable", 32'(result), 32'(held));
            check("bp_start_ready", 32'(start_ready), 32'd0);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_start_ready", 32'(start_ready), 32'd1);
        check("bp_idle_done_valid", 32'(done_valid), 32'd0);
        @(posedge clk);
        q.push_back(e2);
        #1;
        start_valid = 1'b0;
        check("bp_second_accept", 32'(start_ready), 32'd0);
        wait_done(n);
        check("bp2_latency", 32'(n), 32'(NIB));
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            do_op(ra, rb, rs, ref_model(ra, rb, rs));
        end

        // Reset two passes into RUN discards the operation.
        op_a = 16'h1234; op_b = 16'h0FCD; op_sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_done_valid", 32'(done_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_au", 32'({au_in1, au_in2, au_carry_in, au_control}), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_valid) seen++;
        end
        check("abort_never_done", 32'(seen), 32'd0);

        ra = W'($urandom); rb = W'($urandom);
        do_op(ra, rb, 1'b1, ref_model(ra, rb, 1'b1));

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
